// File: rtl/arbiter_wrr_ack.sv
// Weighted round-robin arbiter; a grant is held until the resource acknowledges.
// Optional grant watchdog enabled by defining ARB_WRR_ACK_TIMEOUT_EN.
module arbiter_wrr_ack #(
    parameter int CLIENTS        = 4,
    parameter int MAX_WEIGHT     = 8,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int W             = $clog2(MAX_WEIGHT + 1),
    localparam int IDW           = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_block_arb,
    input  logic [CLIENTS-1:0]     i_req,
    input  logic [CLIENTS*W-1:0]   i_weight,
    input  logic                   i_gnt_ack,
    output logic [CLIENTS-1:0]     o_gnt,
    output logic [IDW-1:0]         o_gnt_id,
    output logic                   o_gnt_valid,
    output logic                   o_timeout
);

    typedef enum logic {ARB, GNT} state_t;

    state_t             state;
    logic [W-1:0]       credit     [CLIENTS];
    logic [W-1:0]       credit_nxt [CLIENTS];
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     ptr_nxt;
    logic [IDW-1:0]     gid_inc;
    logic [IDW-1:0]     win;
    logic [IDW-1:0]     idx;
    logic [CLIENTS-1:0] elig;
    logic [CLIENTS-1:0] onehot;
    logic               found;
    logic               acked;
    logic               arb_en;
    logic               reload;
    logic               expire;

    assign acked   = (state == GNT) && i_gnt_ack;
    assign arb_en  = (state == ARB) || acked;
    assign gid_inc = (o_gnt_id == IDW'(CLIENTS - 1)) ? '0 : o_gnt_id + 1'b1;
    assign reload  = (|i_req) && !i_block_arb && !(|elig);

    // Post-ack view of credits and pointer, so the next winner is picked in the ack cycle.
    always_comb begin
        for (int i = 0; i < CLIENTS; i++) begin
            credit_nxt[i] = credit[i];
        end
        ptr_nxt = ptr;
        if (acked) begin
            if (credit[o_gnt_id] != '0) begin
                credit_nxt[o_gnt_id] = credit[o_gnt_id] - 1'b1;
            end
            ptr_nxt = (credit_nxt[o_gnt_id] == '0) ? gid_inc : o_gnt_id;
        end
        for (int i = 0; i < CLIENTS; i++) begin
            elig[i] = i_req[i] && (credit_nxt[i] != '0) && !i_block_arb;
        end
    end

    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx    = ptr_nxt;
        onehot = '0;
        for (int k = 0; k < CLIENTS; k++) begin
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = (idx == IDW'(CLIENTS - 1)) ? '0 : idx + 1'b1;
        end
        onehot[win] = 1'b1;
    end

`ifdef ARB_WRR_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;

    assign expire = (state == GNT) && !i_gnt_ack && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tcnt <= '0;
        end else if ((state == GNT) && !i_gnt_ack && !expire) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ARB;
            ptr         <= '0;
            o_gnt       <= '0;
            o_gnt_id    <= '0;
            o_gnt_valid <= 1'b0;
            o_timeout   <= 1'b0;
            for (int i = 0; i < CLIENTS; i++) begin
                credit[i] <= '0;
            end
        end else begin
            o_timeout <= 1'b0;
            if (arb_en) begin
                ptr <= ptr_nxt;
                if (reload) begin
                    // A zero weight still earns one grant per round.
                    for (int i = 0; i < CLIENTS; i++) begin
                        credit[i] <= (i_weight[i*W +: W] == '0) ? W'(1) : i_weight[i*W +: W];
                    end
                    state       <= ARB;
                    o_gnt       <= '0;
                    o_gnt_id    <= '0;
                    o_gnt_valid <= 1'b0;
                end else begin
                    for (int i = 0; i < CLIENTS; i++) begin
                        credit[i] <= credit_nxt[i];
                    end
                    if (found) begin
                        state       <= GNT;
                        o_gnt       <= onehot;
                        o_gnt_id    <= win;
                        o_gnt_valid <= 1'b1;
                    end else begin
                        state       <= ARB;
                        o_gnt       <= '0;
                        o_gnt_id    <= '0;
                        o_gnt_valid <= 1'b0;
                    end
                end
            end else if (expire) begin
                credit[o_gnt_id] <= '0;
                ptr              <= gid_inc;
                state            <= ARB;
                o_gnt            <= '0;
                o_gnt_id         <= '0;
                o_gnt_valid      <= 1'b0;
                o_timeout        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_wrr_ack.sv
// Directed bench for arbiter_wrr_ack: weighted rotation, held grants, block, reset.
// Watchdog section depends on ARB_WRR_ACK_TIMEOUT_EN.
module tb_arbiter_wrr_ack;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        block  = 1'b0;
    logic        ack    = 1'b0;
    logic [3:0]  req    = '0;
    logic [15:0] weight = '0;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arbiter_wrr_ack #(
        .CLIENTS        (4),
        .MAX_WEIGHT     (8),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_block_arb (block),
        .i_req       (req),
        .i_weight    (weight),
        .i_gnt_ack   (ack),
        .o_gnt       (gnt),
        .o_gnt_id    (gnt_id),
        .o_gnt_valid (gnt_valid),
        .o_timeout   (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic exp_gnt(input string tag, input int id);
        check({tag, ".gnt"}, 32'(gnt), 32'(1 << id));
        check({tag, ".id"}, 32'(gnt_id), 32'(id));
        check({tag, ".vld"}, 32'(gnt_valid), 32'd1);
    endtask

    task automatic exp_idle(input string tag);
        check({tag, ".gnt"}, 32'(gnt), 32'd0);
        check({tag, ".vld"}, 32'(gnt_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        block = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int seq2 [11] = '{-1, 0, 0, 0, 1, 2, 3, -1, 0, 0, 0};

    initial begin
        tick();
        check("rst.gnt", 32'(gnt), 32'd0);
        check("rst.id", 32'(gnt_id), 32'd0);
        check("rst.vld", 32'(gnt_valid), 32'd0);
        check("rst.tmo", 32'(timeout), 32'd0);

        // Equal weights of 1, immediate ack
        weight = 16'h1111;
        rst_n  = 1'b1;
        req    = 4'hF;
        ack    = 1'b1;
        tick(); exp_idle("t1.reload");
        for (int k = 0; k < 4; k++) begin
            tick(); exp_gnt($sformatf("t1.g%0d", k), k);
        end
        tick(); exp_idle("t1.bubble");
        tick(); exp_gnt("t1.wrap", 0);

        // Weights {3,1,1,1}
        do_reset();
        weight = 16'h1113;
        req    = 4'hF;
        ack    = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
            if (seq2[k] < 0) exp_idle($sformatf("t2.s%0d", k));
            else exp_gnt($sformatf("t2.s%0d", k), seq2[k]);
        end

        // Single client 2, weight 2, delayed ack
        do_reset();
        weight = 16'h1211;
        req    = 4'b0100;
        tick(); exp_idle("t3.reload");
        tick(); exp_gnt("t3.w1", 2);
        req = 4'b0000;
        tick(); exp_gnt("t3.drop", 2);
        req = 4'b0100;
        tick(); exp_gnt("t3.w3", 2);
        ack = 1'b1;
        tick(); exp_gnt("t3.g2", 2);
        ack = 1'b0;
        tick(); exp_gnt("t3.g2w2", 2);
        tick(); exp_gnt("t3.g2w3", 2);
        ack = 1'b1;
        tick(); exp_idle("t3.bubble");
        ack = 1'b0;
        tick(); exp_gnt("t3.g3", 2);

        // Block while granted; client 3 has weight 0
        do_reset();
        weight = 16'h0111;
        req    = 4'hF;
        tick(); exp_idle("t4.reload");
        ack = 1'b1;
        tick(); exp_gnt("t4.g0", 0);
        tick(); exp_gnt("t4.g1", 1);
        ack   = 1'b0;
        block = 1'b1;
        tick(); exp_gnt("t4.hold1", 1);
        tick(); exp_gnt("t4.hold2", 1);
        ack = 1'b1;
        tick(); exp_idle("t4.blk1");
        ack = 1'b0;
        tick(); exp_idle("t4.blk2");
        block = 1'b0;
        tick(); exp_gnt("t4.g2", 2);
        ack = 1'b1;
        tick(); exp_gnt("t4.g3", 3);
        tick(); exp_idle("t4.bubble");
        tick(); exp_gnt("t4.wrap", 0);

        // Asynchronous reset mid-grant
        do_reset();
        weight = 16'h1113;
        req    = 4'hF;
        tick(); exp_idle("t5.reload");
        ack = 1'b1;
        tick(); exp_gnt("t5.g0a", 0);
        tick(); exp_gnt("t5.g0b", 0);
        ack = 1'b0;
        tick(); exp_gnt("t5.hold", 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5.async.gnt", 32'(gnt), 32'd0);
        check("t5.async.vld", 32'(gnt_valid), 32'd0);
        check("t5.async.id", 32'(gnt_id), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); exp_idle("t5.reload2");
        tick(); exp_gnt("t5.first", 0);

        // Grant with no ack
        do_reset();
        weight = 16'h1111;
        req    = 4'b0011;
        tick(); exp_idle("t6.reload");
`ifdef ARB_WRR_ACK_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_gnt($sformatf("t6.c%0d", k), 0);
            check($sformatf("t6.tmo%0d", k), 32'(timeout), 32'd0);
        end
        tick(); exp_idle("t6.revoke");
        check("t6.pulse", 32'(timeout), 32'd1);
        tick(); exp_gnt("t6.next", 1);
        check("t6.pulse_end", 32'(timeout), 32'd0);
`else
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_gnt($sformatf("t6.c%0d", k), 0);
            check($sformatf("t6.tmo%0d", k), 32'(timeout), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
